// File: rtl/token_pacer_pkg.sv
// Shared types and helpers for the token pacer.
// DROP_CNT_W sizes the optional dropped-token counter (TOKEN_PACER_DROP_CNT_EN).
package token_pkg;

    typedef enum logic {
        IDLE  = 1'b0,
        SPACE = 1'b1
    } pacer_state_e;

    localparam int DROP_CNT_W = 16;

    function automatic int cnt_w(input int n);
        return $clog2(n + 1);
    endfunction

endpackage

// File: rtl/token_pacer_gap_timer.sv
// Spacing timer: after a start pulse, holds ready low so the next start
// lands exactly GAP edges later. GAP=1 never leaves IDLE.
module pacer_gap_timer
    import token_pkg::*;
#(
    parameter int GAP = 4
) (
    input  logic clk,
    input  logic rst,
    input  logic start,
    output logic ready
);

    localparam int             G_W    = (GAP > 1) ? $clog2(GAP) : 1;
    localparam logic [G_W-1:0] G_LOAD = G_W'(GAP - 1);
    localparam logic [G_W-1:0] G_ONE  = G_W'(1);

    pacer_state_e   state_q, state_d;
    logic [G_W-1:0] g_q, g_d;

    // Next-state and gap-count logic; start is only honoured while ready.
    always_comb begin
        state_d = state_q;
        g_d     = g_q;
        case (state_q)
            IDLE: begin
                if (start && (GAP > 1)) begin
                    state_d = SPACE;
                    g_d     = G_LOAD;
                end else begin
                    state_d = IDLE;
                    g_d     = g_q;
                end
            end
            SPACE: begin
                g_d = g_q - G_ONE;
                if (g_q == G_ONE) begin
                    state_d = IDLE;
                end else begin
                    state_d = SPACE;
                end
            end
            default: begin
                state_d = IDLE;
                g_d     = {G_W{1'b0}};
            end
        endcase
    end

    // Timer state registers.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= IDLE;
            g_q     <= {G_W{1'b0}};
        end else begin
            state_q <= state_d;
            g_q     <= g_d;
        end
    end

    assign ready = (state_q == IDLE);

endmodule

// File: rtl/token_pacer.sv
// Buffers single-cycle tokens and re-emits them at least GAP cycles apart.
// Define TOKEN_PACER_DROP_CNT_EN to add the saturating drop_cnt output.
module token_pacer
    import token_pkg::*;
#(
    parameter int GAP         = 4,
    parameter int MAX_PENDING = 8,
    parameter int CNT_W       = cnt_w(MAX_PENDING)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             a,
    input  logic             en,
    input  logic             clr,
    output logic             b,
    output logic [CNT_W-1:0] pending,
    output logic             ovf
`ifdef TOKEN_PACER_DROP_CNT_EN
    ,
    output logic [DROP_CNT_W-1:0] drop_cnt
`endif
);

    localparam logic [CNT_W-1:0] MAX_P = CNT_W'(MAX_PENDING);
    localparam logic [CNT_W-1:0] ONE_P = CNT_W'(1);

    logic [CNT_W-1:0] p_q, p_d;
    logic             b_q, b_d;
    logic             ovf_q, ovf_d;
    logic             ready_s, emit_s, full_s, accept_s, drop_s;

    pacer_gap_timer #(
        .GAP(GAP)
    ) u_gap_timer (
        .clk  (clk),
        .rst  (rst),
        .start(emit_s),
        .ready(ready_s)
    );

    // A full counter can still take a token on an emitting edge.
    always_comb begin
        emit_s   = en && (p_q != {CNT_W{1'b0}}) && ready_s;
        full_s   = (p_q == MAX_P);
        accept_s = a && (!full_s || emit_s);
        drop_s   = a && full_s && !emit_s;
        b_d      = emit_s;
        case ({accept_s, emit_s})
            2'b10:   p_d = p_q + ONE_P;
            2'b01:   p_d = p_q - ONE_P;
            default: p_d = p_q;
        endcase
        if (drop_s) begin
            ovf_d = 1'b1;
        end else if (clr) begin
            ovf_d = 1'b0;
        end else begin
            ovf_d = ovf_q;
        end
    end

    // Pending, output pulse and sticky overflow registers.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            p_q   <= {CNT_W{1'b0}};
            b_q   <= 1'b0;
            ovf_q <= 1'b0;
        end else begin
            p_q   <= p_d;
            b_q   <= b_d;
            ovf_q <= ovf_d;
        end
    end

    assign b       = b_q;
    assign pending = p_q;
    assign ovf     = ovf_q;

`ifdef TOKEN_PACER_DROP_CNT_EN
    logic [DROP_CNT_W-1:0] drop_cnt_q, drop_cnt_d;

    // Clear together with a drop leaves just that drop counted.
    always_comb begin
        drop_cnt_d = drop_cnt_q;
        if (clr) begin
            drop_cnt_d = drop_s ? DROP_CNT_W'(1) : {DROP_CNT_W{1'b0}};
        end else if (drop_s && (drop_cnt_q != {DROP_CNT_W{1'b1}})) begin
            drop_cnt_d = drop_cnt_q + DROP_CNT_W'(1);
        end else begin
            drop_cnt_d = drop_cnt_q;
        end
    end

    // Drop counter register.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            drop_cnt_q <= {DROP_CNT_W{1'b0}};
        end else begin
            drop_cnt_q <= drop_cnt_d;
        end
    end

    assign drop_cnt = drop_cnt_q;
`endif

endmodule
